interrupt_controller_n: RTL

INTERRUPT_CONTROLLER_N -- requirements
Module: interrupt_controller_n

---
 rtl/interrupt_controller_n_pkg.sv | 24 ++
 rtl/interrupt_controller_n_rotator.sv | 31 +++
 rtl/interrupt_controller_n.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/interrupt_controller_n_pkg.sv
// Shared definitions for the interrupt controller:
// register map, control bits and FSM states.
package interrupt_controller_n_pkg;

  localparam logic [2:0] ADDR_MASK    = 3'd0;
  localparam logic [2:0] ADDR_TRIGGER = 3'd1;
  localparam logic [2:0] ADDR_VBASE   = 3'd2;
  localparam logic [2:0] ADDR_CTRL    = 3'd3;
  localparam logic [2:0] ADDR_EOI     = 3'd4;
  localparam logic [2:0] ADDR_IRR     = 3'd5;
  localparam logic [2:0] ADDR_ISR     = 3'd6;
  localparam logic [2:0] ADDR_PTR     = 3'd7;

  localparam int CTRL_AUTO_EOI = 0;
  localparam int CTRL_ROTATE   = 1;
  localparam int EOI_SPECIFIC  = 7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQUEST,
    ST_VECTOR
  } ic_state_e;

endpackage

// File: rtl/interrupt_controller_n_rotator.sv
// Rotating priority encoder: channel ptr is highest,
// then ptr+1 and so on, wrapping modulo NUM_IRQ.
module priority_rotator_n #(
  parameter int NUM_IRQ = 16,
  parameter int PW      = $clog2(NUM_IRQ)
) (
  input  logic [NUM_IRQ-1:0] request,
  input  logic [PW-1:0]      ptr,
  output logic               valid,
  output logic [PW-1:0]      index
);

  logic [PW:0] c;

  // Walk from lowest priority to highest so the last hit wins.
  always_comb begin
    valid = 1'b0;
    index = '0;
    c     = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      c = {1'b0, ptr} + (PW+1)'(i);
      if (c >= (PW+1)'(NUM_IRQ))
        c = c - (PW+1)'(NUM_IRQ);
      if (request[c[PW-1:0]]) begin
        valid = 1'b1;
        index = c[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/interrupt_controller_n.sv
// Fully nested, rotating-priority interrupt controller
// with edge/level channels and a CPU ack handshake.
module interrupt_controller_n
  import interrupt_controller_n_pkg::*;
#(
  parameter int NUM_IRQ      = 16,
  parameter int VECTOR_WIDTH = 8
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [NUM_IRQ-1:0]      interrupt_request,
  input  logic                    write_enable,
  input  logic [2:0]              address,
  input  logic [31:0]             data_bus_in,
  input  logic                    read_enable,
  output logic [31:0]             data_bus_out,
  output logic                    interrupt_to_cpu,
  input  logic                    interrupt_acknowledge,
  output logic                    vector_valid,
  output logic [VECTOR_WIDTH-1:0] vector,
  output logic                    spurious
);

  localparam int PW = $clog2(NUM_IRQ);

  logic [NUM_IRQ-1:0]      mask_q, trig_q;
  logic [NUM_IRQ-1:0]      irr_q, isr_q, prev_q;
  logic [VECTOR_WIDTH-1:0] vbase_q, vec_q;
  logic [1:0]              ctrl_q;
  logic [PW-1:0]           ptr_q;
  logic                    spur_q;
  logic [31:0]             rd_q, rd_d;
  ic_state_e               state_q, state_d;

  logic [NUM_IRQ-1:0] irr_eff, rise, eoi_clr, ack_clr;
  logic [NUM_IRQ-1:0] isr_post, isr_d, irr_d;
  logic [NUM_IRQ-1:0] allowed, eligible;
  logic [PW-1:0]      ptr_post, ptr_d, eoi_idx;
  logic               eoi_wr, eoi_hit, lvl_ok, ack_take;
  logic               isr_pre_valid, isr_top_valid, win_valid;
  logic [PW-1:0]      isr_pre_idx, isr_top_idx, win_idx;
  logic               unused_bits;

  assign unused_bits = ^data_bus_in;

  function automatic logic [PW-1:0] next_ch(
    input logic [PW-1:0] ch
  );
    return (ch == PW'(NUM_IRQ - 1)) ? '0 : ch + PW'(1);
  endfunction

  function automatic logic [PW:0] rank_of(
    input logic [PW-1:0] ch,
    input logic [PW-1:0] p
  );
    logic [PW:0] r;
    r = {1'b0, ch} + (PW+1)'(NUM_IRQ) - {1'b0, p};
    if (r >= (PW+1)'(NUM_IRQ))
      r = r - (PW+1)'(NUM_IRQ);
    return r;
  endfunction

  assign irr_eff = (trig_q & irr_q)
                 | (~trig_q & interrupt_request);
  assign rise    = interrupt_request & ~prev_q;
  assign eoi_wr  = write_enable && (address == ADDR_EOI);
  assign lvl_ok  = {27'd0, data_bus_in[4:0]}
                   < 32'(NUM_IRQ);

  priority_rotator_n #(.NUM_IRQ(NUM_IRQ)) u_isr_pre (
    .request (isr_q),
    .ptr     (ptr_q),
    .valid   (isr_pre_valid),
    .index   (isr_pre_idx)
  );

  // EOI is resolved before the acknowledge looks at ISR.
  always_comb begin
    eoi_hit = 1'b0;
    eoi_idx = '0;
    eoi_clr = '0;
    if (eoi_wr) begin
      if (data_bus_in[EOI_SPECIFIC]) begin
        eoi_hit = lvl_ok;
        eoi_idx = PW'(data_bus_in[4:0]);
      end else begin
        eoi_hit = isr_pre_valid;
        eoi_idx = isr_pre_idx;
      end
    end
    if (eoi_hit)
      eoi_clr[eoi_idx] = 1'b1;
    isr_post = isr_q & ~eoi_clr;
    ptr_post = (eoi_hit && ctrl_q[CTRL_ROTATE])
             ? next_ch(eoi_idx) : ptr_q;
  end

  priority_rotator_n #(.NUM_IRQ(NUM_IRQ)) u_isr_top (
    .request (isr_post),
    .ptr     (ptr_post),
    .valid   (isr_top_valid),
    .index   (isr_top_idx)
  );

  always_comb begin
    allowed = '0;
    for (int c = 0; c < NUM_IRQ; c++)
      allowed[c] = !isr_top_valid
        || (rank_of(PW'(c), ptr_post)
            < rank_of(isr_top_idx, ptr_post));
    eligible = irr_eff & ~mask_q & allowed;
  end

  priority_rotator_n #(.NUM_IRQ(NUM_IRQ)) u_win (
    .request (eligible),
    .ptr     (ptr_post),
    .valid   (win_valid),
    .index   (win_idx)
  );

  assign ack_take = (state_q == ST_REQUEST)
                 && interrupt_acknowledge;

  always_comb begin
    isr_d   = isr_post;
    ptr_d   = ptr_post;
    ack_clr = '0;
    if (ack_take && win_valid) begin
      if (!ctrl_q[CTRL_AUTO_EOI])
        isr_d[win_idx] = 1'b1;
      else if (ctrl_q[CTRL_ROTATE])
        ptr_d = next_ch(win_idx);
      if (trig_q[win_idx])
        ack_clr[win_idx] = 1'b1;
    end
    // A fresh edge beats the acknowledge clear.
    irr_d = (irr_q & ~ack_clr) | rise;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      state_q == ST_IDLE:
        if (|eligible) state_d = ST_REQUEST;
      state_q == ST_REQUEST:
        if (ack_take)        state_d = ST_VECTOR;
        else if (!(|eligible)) state_d = ST_IDLE;
      default:
        state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    interrupt_to_cpu = (state_q == ST_REQUEST);
    vector_valid     = (state_q == ST_VECTOR);
    vector           = vector_valid ? vec_q : '0;
    spurious         = vector_valid && spur_q;
  end

  always_comb begin
    unique case (address)
      ADDR_MASK:    rd_d = 32'(mask_q);
      ADDR_TRIGGER: rd_d = 32'(trig_q);
      ADDR_VBASE:   rd_d = 32'(vbase_q);
      ADDR_CTRL:    rd_d = 32'(ctrl_q);
      ADDR_IRR:     rd_d = 32'(irr_eff);
      ADDR_ISR:     rd_d = 32'(isr_q);
      ADDR_PTR:     rd_d = 32'(ptr_q);
      default:      rd_d = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mask_q  <= '1;
      trig_q  <= '0;
      vbase_q <= '0;
      ctrl_q  <= '0;
      irr_q   <= '0;
      isr_q   <= '0;
      ptr_q   <= '0;
      prev_q  <= '0;
      vec_q   <= '0;
      spur_q  <= 1'b0;
      rd_q    <= '0;
    end else begin
      irr_q  <= irr_d;
      isr_q  <= isr_d;
      ptr_q  <= ptr_d;
      prev_q <= interrupt_request;
      rd_q   <= read_enable ? rd_d : '0;
      if (ack_take) begin
        spur_q <= !win_valid;
        vec_q  <= win_valid
          ? vbase_q + VECTOR_WIDTH'(win_idx)
          : vbase_q + VECTOR_WIDTH'(NUM_IRQ - 1);
      end
      if (write_enable) begin
        unique case (address)
          ADDR_MASK:
            mask_q <= data_bus_in[NUM_IRQ-1:0];
          ADDR_TRIGGER:
            trig_q <= data_bus_in[NUM_IRQ-1:0];
          ADDR_VBASE:
            vbase_q <= data_bus_in[VECTOR_WIDTH-1:0];
          ADDR_CTRL:
            ctrl_q <= data_bus_in[1:0];
          default: ;
        endcase
      end
    end
  end

  assign data_bus_out = rd_q;

endmodule
